// File: rtl/tone_bit_unpacker.sv
// Bit-field unpacker between the byte FIFO and the constellation encoder.
// Buffers FIFO bytes and returns 0..BMAX-bit fields LSB-first, one per request.
module tone_bit_unpacker #(
    parameter int DWIDTH = 8,
    parameter int BMAX   = 15,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    output logic              fifo_re_o,
    input  logic              req_i,
    input  logic [CW-1:0]     nbits_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [BMAX-1:0]   bits_o,
    output logic              bits_valid_o,
    output logic [4:0]        level_o
);

    localparam int BW = BMAX + DWIDTH - 1;
    localparam int LW = 5;
    localparam logic [BW-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, FILL, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   req_n_q, req_n_d;
    logic [BMAX-1:0] bits_q, bits_d;
    logic            valid_q, valid_d;

    logic [CW-1:0]   n_eff;
    logic [CW-1:0]   take_n;
    logic [BW-1:0]   cap_acc, src_acc, mask;
    logic [LW-1:0]   cap_level, src_level;
    logic            emit;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        level_d   = level_q;
        req_n_d   = req_n_q;
        bits_d    = bits_q;
        valid_d   = 1'b0;
        fifo_re_o = 1'b0;
        emit      = 1'b0;

        n_eff     = (nbits_i > CW'(BMAX)) ? CW'(BMAX) : nbits_i;
        // The popped byte lands just above the bits already buffered.
        cap_acc   = acc_q | (BW'(fifo_data_i) << level_q);
        cap_level = level_q + LW'(DWIDTH);
        src_acc   = acc_q;
        src_level = level_q;
        take_n    = n_eff;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (level_q >= LW'(n_eff)) begin
                        emit = 1'b1;
                    end else begin
                        req_n_d = n_eff;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                fifo_re_o = !fifo_empty_i;
                if (!fifo_empty_i) state_d = CAPTURE;
            end
            CAPTURE: begin
                src_acc   = cap_acc;
                src_level = cap_level;
                take_n    = req_n_q;
                if (cap_level >= LW'(req_n_q)) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d   = cap_acc;
                    level_d = cap_level;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        mask = ~(ONES << take_n);
        if (emit) begin
            bits_d  = BMAX'(src_acc & mask);
            acc_d   = src_acc >> take_n;
            level_d = src_level - LW'(take_n);
            valid_d = 1'b1;
        end

        // Flush drops everything, including a byte captured this cycle.
        if (flush_i) begin
            state_d   = IDLE;
            acc_d     = '0;
            level_d   = '0;
            bits_d    = bits_q;
            valid_d   = 1'b0;
            fifo_re_o = 1'b0;
        end
        if (reset) fifo_re_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            level_q <= '0;
            req_n_q <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            req_n_q <= req_n_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign bits_o       = bits_q;
    assign bits_valid_o = valid_q;
    assign level_o      = level_q;

endmodule

// File: tb/tb_tone_bit_unpacker.sv
// Bench for tone_bit_unpacker: bit-queue reference model, per-cycle compare,
// directed scenarios plus randomized requests against a registered-read FIFO.
module tb_tone_bit_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty_i = 1'b1;
    logic [7:0]  fifo_data_i = '0;
    logic        fifo_re_o;
    logic        req_i = 1'b0;
    logic [3:0]  nbits_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic [14:0] bits_o;
    logic        bits_valid_o;
    logic [4:0]  level_o;

    tone_bit_unpacker #(.DWIDTH(8), .BMAX(15), .CW(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
        .fifo_re_o(fifo_re_o), .req_i(req_i), .nbits_i(nbits_i), .flush_i(flush_i),
        .ready_o(ready_o), .bits_o(bits_o), .bits_valid_o(bits_valid_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct { int cyc; int bits; int lvl; } exp_t;
    exp_t       expq[$];
    bit         mq[$];          // model: buffered bits, oldest first
    int         fq_b[$];        // model: FIFO bytes not yet fetched
    int         fq_t[$];        // model: cycle each byte became visible
    logic [7:0] dq[$];          // the FIFO the DUT actually reads

    bit chk_on = 1'b0;
    bit re_s = 1'b0;
    bit pend = 1'b0;
    int pend_n, pend_k;
    int pops = 0;
    int busy_lo = 1, busy_hi = 0;
    int idle_level = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, ecount);
        end
    endtask

    // Emit cycle: each byte is popped one edge after it is both visible and
    // wanted, and captured on the following edge.
    function automatic bit model_req(input int n, input int k);
        int ne, nb, t, a, b, v;
        ne = (n > 15) ? 15 : n;
        nb = 0;
        while (mq.size() + 8 * nb < ne) nb++;
        if (nb > fq_b.size()) return 1'b0;
        t = k;
        for (int i = 0; i < nb; i++) begin
            a = fq_t.pop_front();
            b = fq_b.pop_front();
            t = ((t > a) ? t : a) + 2;
            for (int j = 0; j < 8; j++) mq.push_back(b[j]);
        end
        v = 0;
        for (int i = 0; i < ne; i++) if (mq.pop_front()) v |= (1 << i);
        expq.push_back('{t, v, mq.size()});
        busy_lo = k;
        busy_hi = t - 1;
        return 1'b1;
    endfunction

    task automatic tick();
        #2 re_s = fifo_re_o;
        @(posedge clk);
        #1;
        if (re_s && dq.size() > 0) begin
            fifo_data_i = dq.pop_front();
            pops++;
        end
        fifo_empty_i = (dq.size() == 0);
    endtask

    task automatic fifo_write(input int v);
        dq.push_back(v[7:0]);
        fq_b.push_back(v & 255);
        fq_t.push_back(ecount);
        fifo_empty_i = 1'b0;
        if (pend && model_req(pend_n, pend_k)) pend = 1'b0;
    endtask

    task automatic do_req(input int n, output int k);
        req_i   = 1'b1;
        nbits_i = 4'(n);
        k = ecount + 1;
        if (!model_req(n, k)) begin
            pend = 1'b1; pend_n = n; pend_k = k;
            busy_lo = k; busy_hi = 1 << 30;
        end
        tick();
        req_i = 1'b0;
    endtask

    // Requests raised while busy must be ignored, so wiggle req_i meanwhile.
    task automatic wait_emit();
        int g = 0;
        while (pend || (expq.size() > 0 && ecount < expq[expq.size()-1].cyc)) begin
            if (g >= 100) begin
                n_checks++; n_fail++;
                $display("FAIL wait_emit: no emit within 100 cycles (cycle %0d)", ecount);
                break;
            end
            req_i   = 1'($urandom);
            nbits_i = 4'($urandom);
            tick();
            g++;
        end
        req_i = 1'b0;
    endtask

    always @(negedge clk) begin : compare
        bit rdy;
        if (chk_on) begin
            while (expq.size() > 0 && expq[0].cyc < ecount) begin
                n_checks++; n_fail++;
                $display("FAIL missed_emit: expected strobe at cycle %0d, now %0d", expq[0].cyc, ecount);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == ecount) begin
                check("valid", bits_valid_o, 1);
                check("bits", bits_o, expq[0].bits);
                check("level_at_emit", level_o, expq[0].lvl);
                idle_level = expq[0].lvl;
                void'(expq.pop_front());
            end else begin
                check("no_valid", bits_valid_o, 0);
            end
            rdy = !(ecount >= busy_lo && ecount <= busy_hi);
            check("ready", ready_o, rdy);
            if (rdy) begin
                check("level_idle", level_o, idle_level);
                check("no_read_idle", fifo_re_o, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p0, w;

        fifo_write('hA5);
        req_i = 1'b1; nbits_i = 4'd4;
        repeat (3) tick();
        check("rst_ready", ready_o, 1);
        check("rst_level", level_o, 0);
        check("rst_valid", bits_valid_o, 0);
        check("rst_re", fifo_re_o, 0);
        check("rst_bits", bits_o, 0);
        check("rst_no_pop", pops, 0);
        reset = 1'b0; req_i = 1'b0;
        tick();
        chk_on = 1'b1;

        do_req(4, k); wait_emit();
        check("a5_lat", ecount - k, 2);
        check("a5_lo", bits_o, 'h5);
        check("a5_lvl", level_o, 4);
        p0 = pops;
        do_req(4, k);
        check("a5_hi", bits_o, 'hA);
        check("a5_hi_lvl", level_o, 0);
        check("a5_hi_nopop", pops, p0);

        fifo_write('h34); fifo_write('h12);
        do_req(12, k); wait_emit();
        check("w12_lat", ecount - k, 4);
        check("w12_bits", bits_o, 'h234);
        check("w12_lvl", level_o, 4);
        do_req(4, k);
        check("w12_rest", bits_o, 'h1);

        fifo_write('hFF); fifo_write('h7F);
        do_req(15, k); wait_emit();
        check("w15_bits", bits_o, 'h7FFF);
        check("w15_lvl", level_o, 1);
        do_req(0, k);
        check("zero_valid", bits_valid_o, 1);
        check("zero_bits", bits_o, 0);
        check("zero_lvl", level_o, 1);
        do_req(1, k);
        check("drain_lvl", level_o, 0);

        do_req(8, k);
        repeat (3) begin
            tick();
            check("stall_no_re", fifo_re_o, 0);
            check("stall_busy", ready_o, 0);
        end
        w = ecount;
        fifo_write('hC3);
        wait_emit();
        check("stall_lat", ecount - w, 2);
        check("stall_bits", bits_o, 'hC3);

        fifo_write('hA5);
        do_req(4, k); wait_emit();
        check("fl_pre_lvl", level_o, 4);
        fifo_write('h11);
        do_req(12, k);
        tick();
        flush_i = 1'b1;
        void'(expq.pop_back());
        mq.delete();
        busy_hi = k + 1;
        tick();
        flush_i = 1'b0;
        idle_level = 0;
        check("fl_valid", bits_valid_o, 0);
        check("fl_lvl", level_o, 0);
        check("fl_ready", ready_o, 1);
        check("fl_fifo_empty", dq.size(), 0);

        for (int it = 0; it < 300; it++) begin
            while (fq_b.size() < 2) fifo_write(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0) begin
                flush_i = 1'b1; req_i = 1'($urandom); nbits_i = 4'($urandom);
                tick();
                flush_i = 1'b0; req_i = 1'b0;
                mq.delete();
                idle_level = 0;
            end else begin
                do_req(int'($urandom_range(0, 15)), k);
                wait_emit();
            end
        end
        repeat (3) tick();
        check("all_emits_seen", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_bit_unpacker.md
Name: tone_bit_unpacker

Overview:
Sits directly downstream of the byte FIFO in the tone order / constellation encoder datapath. Pops bytes from the FIFO into a bit accumulator and, on request, returns a variable-width bit field of 0..15 bits, one field per tone as set by the bit-loading table. Bits are consumed LSB-first: bit 0 of the oldest byte is the first bit delivered.

Parameters:
DWIDTH, 8, FIFO data width in bits
BMAX, 15, maximum bits per request
CW, 4, width of the bit-count request field (must be able to hold BMAX)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
fifo_empty_i  in  1  FIFO empty flag
fifo_data_i  in  DWIDTH  FIFO read data; valid the cycle after fifo_re_o is sampled (registered read)
fifo_re_o  out  1  FIFO read enable, combinational
req_i  in  1  single-cycle request for a bit field
nbits_i  in  CW  requested field width, 0..BMAX, sampled with req_i
flush_i  in  1  discard all buffered bits (symbol boundary)
ready_o  out  1  block accepts req_i this cycle
bits_o  out  BMAX  extracted field, right-aligned, upper bits zero
bits_valid_o  out  1  one-cycle strobe qualifying bits_o
level_o  out  5  number of valid bits currently buffered (0..BMAX+DWIDTH-1)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Internal state: accumulator buf of BMAX+DWIDTH-1 = 22 bits; level counter (5 bit); latched width req_n; FSM states IDLE, FILL, CAPTURE.
- Reset values: state IDLE; buf = 0; level = 0; bits_o = 0; bits_valid_o = 0; ready_o = 1; fifo_re_o = 0.
- ready_o = 1 only in IDLE. req_i is ignored when ready_o = 0.
- IDLE, req_i sampled at edge k:
  - If level >= nbits_i: at edge k, register bits_o = buf & mask(nbits_i); shift buf right by nbits_i; level -= nbits_i; bits_valid_o = 1 for one cycle. State stays IDLE, so back-to-back requests are legal.
  - Otherwise: latch req_n and go to FILL.
- FILL: fifo_re_o = !fifo_empty_i. If the FIFO is not empty, go to CAPTURE at the next edge. If it is empty, stay in FILL indefinitely (stall); no timeout.
- CAPTURE, at the edge:
  - new_buf = buf | (fifo_data_i << level); new_level = level + 8.
  - If new_level >= req_n: emit from new_buf in the same edge, using the same extract/shift rule as IDLE, and return to IDLE.
  - Otherwise go back to FILL.
- Latency: valid at edge k when bits are already buffered; valid at edge k+2n when n bytes are fetched with no stall (n ≤ 2). Each empty-FIFO cycle in FILL adds one cycle.
- Occupancy bound: bytes are fetched only while level < req_n ≤ 15, so level never exceeds 22. Overflow is impossible by construction.
- nbits_i = 0: emit immediately with bits_o = 0, bits_valid_o = 1, level unchanged, no FIFO read.
- nbits_i > BMAX: treated as BMAX.
- bits_valid_o is 0 in every cycle without an emit. bits_o holds its last value.
- flush_i has priority over everything except reset:
  - At the edge: buf = 0, level = 0, state = IDLE, no emit.
  - fifo_re_o is forced 0 in the same cycle.
  - A byte already popped (flush while in CAPTURE) is discarded.
  - req_i in the flush cycle is ignored.
- reset mid-operation behaves like flush and also clears bits_o. Any popped byte is lost.

Test Plan:
- Reset → ready_o = 1, level_o = 0, bits_valid_o = 0, fifo_re_o = 0; hold reset during req_i → no fifo_re_o.
- FIFO holds 0xA5; req 4 → one fifo_re_o pulse, bits_o = 0x5 at k+2, level_o = 4. Next req 4 → bits_o = 0xA at edge k with no FIFO read, level_o = 0.
- FIFO 0x34, 0x12; req 12 → two pops, bits_o = 0x234 at k+4, level_o = 4. Req 4 → 0x1.
- FIFO 0xFF, 0x7F; req 15 → bits_o = 0x7FFF, level_o = 1. Req 0 → bits_o = 0, valid = 1, level_o stays 1.
- Empty FIFO, req 8 → FSM stays in FILL with fifo_re_o = 0 and ready_o = 0. Write 0xC3 three cycles later → bits_o = 0xC3 two cycles after the write becomes visible.
- Level 4 (from 0xA5), req 12 with FIFO holding 0x11: assert flush_i in the CAPTURE cycle → no bits_valid_o, level_o = 0, ready_o = 1. FIFO is now empty (byte discarded).
